// File: rtl/cla_arb_pkg.sv
// Shared types, constants and round-robin pick function for the CLA adder arbiter.
package cla_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DATA_W  = 9;
  localparam int RES_W   = DATA_W + 1;
  localparam int MAX_REQ = 8;
  localparam int PTR_W   = 3;

  // Scan valid starting at ptr, wrapping modulo n; first set bit wins (one-hot).
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [PTR_W-1:0]   ptr,
    input int                 n
  );
    logic [MAX_REQ-1:0] grant;
    logic               found;
    logic [PTR_W-1:0]   k;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      k = PTR_W'((int'(ptr) + i) % n);
      if ((i < n) && !found && valid[k]) begin
        grant[k] = 1'b1;
        found    = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/cla_adder.sv
// 9-bit carry-lookahead adder cell; carry-in is tied to 0 inside the cell.
module cla_adder (
  input  logic [cla_arb_pkg::DATA_W-1:0] i_add1,
  input  logic [cla_arb_pkg::DATA_W-1:0] i_add2,
  output logic [cla_arb_pkg::RES_W-1:0]  o_result
);

  localparam int W = cla_arb_pkg::DATA_W;

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;
  logic         c_next;
  logic         prop;

  // Each carry is a flat sum of generate terms gated by the propagate chain above them.
  always_comb begin
    g      = i_add1 & i_add2;
    p      = i_add1 ^ i_add2;
    c      = '0;
    c_next = 1'b0;
    prop   = 1'b0;
    for (int i = 0; i < W; i++) begin
      c_next = g[i];
      prop   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c_next = c_next | (prop & g[j]);
        prop   = prop & p[j];
      end
      c[i+1] = c_next;
    end
  end

  assign o_result = {c[W], p ^ c[W-1:0]};

endmodule

// File: rtl/cla_rr_picker.sv
// Combinational rotate-priority encoder: one-hot grant, its index and any_valid.
module cla_rr_picker
  import cla_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_valid
);

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] grant_ext;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    grant_ext      = rr_pick(req_ext, PTR_W'(ptr), N);
    grant_idx      = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (grant_ext[i]) grant_idx = IDX_W'(i);
    end
  end

  assign grant     = grant_ext[N-1:0];
  assign any_valid = |grant_ext;

endmodule

// File: rtl/cla_adder_arbiter.sv
// Round-robin share of one 9-bit CLA adder between NUM_REQ requesters.
// Optional statistics counters are enabled with CLA_ADDER_ARB_STATS_EN.
module cla_adder_arbiter
  import cla_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 9,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_add1,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_add2,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [ID_W-1:0]           o_rsp_id,
  output logic [DATA_W:0]           o_rsp_result,
  output logic                      o_busy,
`ifdef CLA_ADDER_ARB_STATS_EN
  output logic [15:0]               o_stat_grants,
  output logic [15:0]               o_stat_carry,
`endif
  output state_t                    o_dbg_state,
  output logic [ID_W-1:0]           o_dbg_rr_ptr
);

  if (DATA_W != cla_arb_pkg::DATA_W) begin : g_bad_data_w
    $error("cla_adder_arbiter: DATA_W must be 9 to match the adder cell");
  end
  if ((NUM_REQ < 2) || (NUM_REQ > MAX_REQ)) begin : g_bad_num_req
    $error("cla_adder_arbiter: NUM_REQ must be in 2..8");
  end

  // Handshake: a request transfers on a cycle where i_req_valid[k] & o_req_ready[k];
  // a response transfers where o_rsp_valid & i_rsp_ready, and result/id hold until then.

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     id_q;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [DATA_W:0]     sum;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                any_valid;
  logic                accepting;
  logic                fire;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic [ID_W-1:0]     next_ptr;

  cla_rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_picker (
    .req       (i_req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  cla_adder u_adder (
    .i_add1   (op_a),
    .i_add2   (op_b),
    .o_result (sum)
  );

  assign accepting   = !i_rst && ((state == IDLE) || ((state == RESP) && i_rsp_ready));
  assign o_req_ready = accepting ? grant : '0;
  assign fire        = accepting && any_valid;
  assign next_ptr    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Only the granted slice is gated through, so X on idle requesters never reaches the latch.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_a = i_req_add1[k*DATA_W +: DATA_W];
        sel_b = i_req_add2[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      id_q         <= '0;
      op_a         <= '0;
      op_b         <= '0;
      o_rsp_valid  <= 1'b0;
      o_rsp_id     <= '0;
      o_rsp_result <= '0;
      o_busy       <= 1'b0;
    end else begin
      if (fire) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        id_q   <= grant_idx;
        rr_ptr <= next_ptr;
      end
      case (state)
        IDLE: begin
          if (fire) begin
            state  <= EXEC;
            o_busy <= 1'b1;
          end
        end
        EXEC: begin
          o_rsp_result <= sum;
          o_rsp_id     <= id_q;
          o_rsp_valid  <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            if (fire) begin
              state <= EXEC;
            end else begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          o_busy      <= 1'b0;
          o_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLA_ADDER_ARB_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stat_grants <= '0;
      o_stat_carry  <= '0;
    end else begin
      if (fire && (o_stat_grants != 16'hFFFF)) o_stat_grants <= o_stat_grants + 16'd1;
      if ((state == EXEC) && sum[DATA_W] && (o_stat_carry != 16'hFFFF))
        o_stat_carry <= o_stat_carry + 16'd1;
    end
  end
`endif

  assign o_dbg_state  = state;
  assign o_dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_cla_adder_arbiter.sv
// Directed self-checking bench for cla_adder_arbiter (NUM_REQ=4, DATA_W=9).
module tb_cla_adder_arbiter;
  import cla_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 9;
  localparam int IW = 2;

  logic            i_clk;
  logic            i_rst;
  logic [N-1:0]    i_req_valid;
  logic [N-1:0]    o_req_ready;
  logic [N*DW-1:0] i_req_add1;
  logic [N*DW-1:0] i_req_add2;
  logic            o_rsp_valid;
  logic            i_rsp_ready;
  logic [IW-1:0]   o_rsp_id;
  logic [DW:0]     o_rsp_result;
  logic            o_busy;
`ifdef CLA_ADDER_ARB_STATS_EN
  logic [15:0]     o_stat_grants;
  logic [15:0]     o_stat_carry;
`endif
  state_t          o_dbg_state;
  logic [IW-1:0]   o_dbg_rr_ptr;

  int checks = 0;
  int errors = 0;
  logic [IW+DW:0] exp_q[$];

  cla_adder_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ID_W(IW)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_add1    (i_req_add1),
    .i_req_add2    (i_req_add2),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_id      (o_rsp_id),
    .o_rsp_result  (o_rsp_result),
    .o_busy        (o_busy),
`ifdef CLA_ADDER_ARB_STATS_EN
    .o_stat_grants (o_stat_grants),
    .o_stat_carry  (o_stat_carry),
`endif
    .o_dbg_state   (o_dbg_state),
    .o_dbg_rr_ptr  (o_dbg_rr_ptr)
  );

  // Clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_op(input int k, input int a, input int b);
    i_req_add1[k*DW +: DW] = DW'(a);
    i_req_add2[k*DW +: DW] = DW'(b);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_req_valid = '0; i_rsp_ready = 1'b0;
    i_req_add1 = '0; i_req_add2 = '0;
    tick(); tick();
    i_rst = 1'b0;
    #1;
    checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d expected 0", o_rsp_valid); end
    checks++; if (o_req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", o_req_ready); end
    checks++; if (o_rsp_result !== 10'd0 || o_rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp: got %0d/%0d expected 0/0", o_rsp_result, o_rsp_id); end
    checks++; if (o_busy !== 1'b0 || o_dbg_state !== IDLE || o_dbg_rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_state: got busy %0d state %0d ptr %0d expected 0 0 0", o_busy, o_dbg_state, o_dbg_rr_ptr); end
  endtask

  task automatic test_single();
    set_op(0, 100, 27);
    i_req_valid = 4'b0001;
    #1;
    checks++; if (o_req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", o_req_ready); end
    tick();
    i_req_valid = '0;
    #1;
    checks++; if (o_rsp_valid !== 1'b0 || o_busy !== 1'b1 || o_req_ready !== 4'b0000) begin errors++; $display("FAIL single_exec: got valid %0d busy %0d ready %b expected 0 1 0000", o_rsp_valid, o_busy, o_req_ready); end
    tick();
    checks++; if (o_rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0d expected 1", o_rsp_valid); end
    checks++; if (o_rsp_result !== 10'd127) begin errors++; $display("FAIL single_result: got %0d expected 127", o_rsp_result); end
    checks++; if (o_rsp_id !== 2'd0 || o_dbg_rr_ptr !== 2'd1) begin errors++; $display("FAIL single_id_ptr: got %0d/%0d expected 0/1", o_rsp_id, o_dbg_rr_ptr); end
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    #1;
    checks++; if (o_rsp_valid !== 1'b0 || o_busy !== 1'b0 || o_dbg_state !== IDLE) begin errors++; $display("FAIL single_drain: got valid %0d busy %0d expected 0 0", o_rsp_valid, o_busy); end
  endtask

  task automatic test_sparse();
    set_op(3, 50, 60);
    i_req_valid = 4'b1000;
    #1;
    checks++; if (o_req_ready !== 4'b1000) begin errors++; $display("FAIL sparse_grant: got %b expected 1000", o_req_ready); end
    tick();
    i_req_valid = '0;
    tick();
    checks++; if (o_rsp_result !== 10'd110 || o_rsp_id !== 2'd3) begin errors++; $display("FAIL sparse_rsp: got %0d id %0d expected 110 id 3", o_rsp_result, o_rsp_id); end
    checks++; if (o_dbg_rr_ptr !== 2'd0) begin errors++; $display("FAIL sparse_ptr: got %0d expected 0", o_dbg_rr_ptr); end
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
  endtask

  task automatic test_carry();
    set_op(2, 511, 511);
    i_req_valid = 4'b0100;
    #1;
    checks++; if (o_req_ready !== 4'b0100) begin errors++; $display("FAIL carry_grant: got %b expected 0100", o_req_ready); end
    tick();
    i_req_valid = '0;
    tick();
    checks++; if (o_rsp_result !== 10'd1022 || o_rsp_result[9] !== 1'b1) begin errors++; $display("FAIL carry_result: got %0d expected 1022", o_rsp_result); end
    checks++; if (o_rsp_id !== 2'd2 || o_dbg_rr_ptr !== 2'd3) begin errors++; $display("FAIL carry_id_ptr: got %0d/%0d expected 2/3", o_rsp_id, o_dbg_rr_ptr); end
`ifdef CLA_ADDER_ARB_STATS_EN
    checks++; if (o_stat_carry !== 16'd1 || o_stat_grants !== 16'd3) begin errors++; $display("FAIL carry_stats: got %0d/%0d expected 1/3", o_stat_carry, o_stat_grants); end
`endif
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    set_op(0, 5, 6);
    i_req_valid = 4'b0001;
    #1;
    checks++; if (o_req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_grant: got %b expected 0001", o_req_ready); end
    tick();
    i_req_valid = '0;
    checks++; if (o_dbg_state !== EXEC) begin errors++; $display("FAIL midrst_exec: got %0d expected %0d", o_dbg_state, EXEC); end
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    #1;
    checks++; if (o_rsp_valid !== 1'b0 || o_rsp_result !== 10'd0 || o_rsp_id !== 2'd0 || o_busy !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got valid %0d result %0d id %0d busy %0d expected all 0", o_rsp_valid, o_rsp_result, o_rsp_id, o_busy); end
    checks++; if (o_dbg_rr_ptr !== 2'd0 || o_dbg_state !== IDLE) begin errors++; $display("FAIL midrst_ptr: got ptr %0d state %0d expected 0 0", o_dbg_rr_ptr, o_dbg_state); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_rsp: got %0d expected 0", o_rsp_valid); end
    end
  endtask

  task automatic test_back_to_back();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] exp_rdy;
    logic [IW+DW:0] exp;
    for (int k = 0; k < N; k++) set_op(k, k * 10 + 1, k + 2);
    i_req_valid = 4'b1111;
    i_rsp_ready = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      exp_rdy = N'(1 << order[n]);
      checks++; if (o_req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", n, o_req_ready, exp_rdy); end
      exp_q.push_back({IW'(order[n]), 10'(11 * order[n] + 3)});
      tick();
      checks++; if (o_rsp_valid !== 1'b0 || o_req_ready !== 4'b0000) begin errors++; $display("FAIL rr_exec%0d: got valid %0d ready %b expected 0 0000", n, o_rsp_valid, o_req_ready); end
      if (n == 4) i_req_valid = '0;
      tick();
      exp = exp_q.pop_front();
      checks++; if (o_rsp_valid !== 1'b1 || {o_rsp_id, o_rsp_result} !== exp) begin errors++; $display("FAIL rr_rsp%0d: got id %0d result %0d expected id %0d result %0d", n, o_rsp_id, o_rsp_result, exp[IW+DW:DW+1], exp[DW:0]); end
    end
    tick();
    i_rsp_ready = 1'b0;
    checks++; if (o_dbg_state !== IDLE || o_dbg_rr_ptr !== 2'd1) begin errors++; $display("FAIL rr_end: got state %0d ptr %0d expected 0 1", o_dbg_state, o_dbg_rr_ptr); end
  endtask

  task automatic test_backpressure();
    set_op(0, 200, 300);
    i_req_valid = 4'b0001;
    #1;
    checks++; if (o_req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant0: got %b expected 0001", o_req_ready); end
    tick();
    set_op(1, 7, 8);
    i_req_valid = 4'b0010;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (o_rsp_valid !== 1'b1 || o_rsp_result !== 10'd500 || o_rsp_id !== 2'd0 || o_req_ready !== 4'b0000) begin errors++; $display("FAIL bp_hold%0d: got valid %0d result %0d id %0d ready %b expected 1 500 0 0000", i, o_rsp_valid, o_rsp_result, o_rsp_id, o_req_ready); end
      tick();
    end
    i_rsp_ready = 1'b1;
    #1;
    checks++; if (o_req_ready !== 4'b0010) begin errors++; $display("FAIL bp_accept: got %b expected 0010", o_req_ready); end
    tick();
    i_req_valid = '0;
    i_rsp_ready = 1'b0;
    #1;
    checks++; if (o_rsp_valid !== 1'b0 || o_dbg_state !== EXEC) begin errors++; $display("FAIL bp_exec: got valid %0d state %0d expected 0 %0d", o_rsp_valid, o_dbg_state, EXEC); end
    tick();
    checks++; if (o_rsp_result !== 10'd15 || o_rsp_id !== 2'd1 || o_dbg_rr_ptr !== 2'd2) begin errors++; $display("FAIL bp_rsp1: got %0d id %0d ptr %0d expected 15 id 1 ptr 2", o_rsp_result, o_rsp_id, o_dbg_rr_ptr); end
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_sparse();
    test_carry();
    test_reset_mid_op();
    test_back_to_back();
    test_backpressure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
